regfile_wb: RTL and testbench

Writeback arbiter and pending-write scoreboard on the producer side of the register file write port. Merges results from two producers (ALU and memory/load unit) through valid/ready handshakes. Drives one registered write per cycle onto the register file's `enable`/`wreg`/`wdata` inputs. Exports a per-register busy bitmap for the decode stage's hazard check.

---
 rtl/regfile_pkg.sv | 13 +
 rtl/wb_scoreboard.sv | 39 +++
 rtl/regfile_wb.sv | 91 +++++++++
 tb/tb_regfile_wb.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and types for the register file writeback path.
// Holds default geometry and the arbiter's port identifiers.
package regfile_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int DEPTH_DEF = 32;

    typedef enum logic {
        PORT_ALU = 1'b0,
        PORT_MEM = 1'b1
    } port_t;

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-write bitmap: set on issue, cleared when the write commits.
// Register 0 is never marked busy.
module wb_scoreboard
    import regfile_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int ADDR  = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             issue_valid,
    input  logic [ADDR-1:0]  issue_reg,
    input  logic             clr_valid,
    input  logic [ADDR-1:0]  clr_reg,
    output logic [DEPTH-1:0] busy
);

    localparam logic [DEPTH-1:0] R0_MASK = {{(DEPTH-1){1'b1}}, 1'b0};

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] set_vec;
    logic [DEPTH-1:0] clr_vec;

    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (issue_valid) set_vec = DEPTH'(1) << issue_reg;
        if (clr_valid)   clr_vec = DEPTH'(1) << clr_reg;
    end

    // Set is applied after clear so a same-edge reissue keeps the bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) busy_q <= '0;
        else        busy_q <= ((busy_q & ~clr_vec) | set_vec) & R0_MASK;
    end

    assign busy = busy_q;

endmodule

// File: rtl/regfile_wb.sv
// Two-port writeback arbiter with registered register-file write port.
// Define REGFILE_WB_SCOREBOARD_EN to build the pending-write scoreboard.
module regfile_wb
    import regfile_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF,
    localparam int ADDR = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             alu_valid,
    output logic             alu_ready,
    input  logic [ADDR-1:0]  alu_reg,
    input  logic [WIDTH-1:0] alu_data,
    input  logic             mem_valid,
    output logic             mem_ready,
    input  logic [ADDR-1:0]  mem_reg,
    input  logic [WIDTH-1:0] mem_data,
    input  logic             issue_valid,
    input  logic [ADDR-1:0]  issue_reg,
    output logic [DEPTH-1:0] busy,
    output logic             wb_enable,
    output logic [ADDR-1:0]  wb_reg,
    output logic [WIDTH-1:0] wb_data
);

    port_t            ptr;
    logic             grant_alu;
    logic             grant_mem;
    logic             grant;
    logic [ADDR-1:0]  win_reg;
    logic [WIDTH-1:0] win_data;

    always_comb begin
        grant_alu = 1'b0;
        grant_mem = 1'b0;
        if (reset) begin
            if (alu_valid && mem_valid) begin
                grant_alu = (ptr == PORT_ALU);
                grant_mem = (ptr == PORT_MEM);
            end else begin
                grant_alu = alu_valid;
                grant_mem = mem_valid;
            end
        end
    end

    assign alu_ready = grant_alu;
    assign mem_ready = grant_mem;
    assign grant     = grant_alu | grant_mem;
    assign win_reg   = grant_alu ? alu_reg  : mem_reg;
    assign win_data  = grant_alu ? alu_data : mem_data;

    // Writes to r0 are consumed but never reach the register file.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr       <= PORT_MEM;
            wb_enable <= 1'b0;
            wb_reg    <= '0;
            wb_data   <= '0;
        end else begin
            wb_enable <= grant && (win_reg != '0);
            if (grant) begin
                wb_reg  <= win_reg;
                wb_data <= win_data;
                ptr     <= grant_alu ? PORT_MEM : PORT_ALU;
            end
        end
    end

`ifdef REGFILE_WB_SCOREBOARD_EN
    wb_scoreboard #(
        .DEPTH (DEPTH),
        .ADDR  (ADDR)
    ) u_scoreboard (
        .clk         (clk),
        .reset       (reset),
        .issue_valid (issue_valid),
        .issue_reg   (issue_reg),
        .clr_valid   (wb_enable),
        .clr_reg     (wb_reg),
        .busy        (busy)
    );
`else
    logic unused_issue;
    assign unused_issue = ^{issue_valid, issue_reg};
    assign busy = '0;
`endif

endmodule

// File: tb/tb_regfile_wb.sv
// Directed bench for regfile_wb: vector table plus corner sequences.
// Busy expectations follow whether REGFILE_WB_SCOREBOARD_EN is defined.
module tb_regfile_wb;

`ifdef REGFILE_WB_SCOREBOARD_EN
    localparam logic SB = 1'b1;
`else
    localparam logic SB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid, mem_valid, alu_ready, mem_ready;
    logic [4:0]  alu_reg, mem_reg, issue_reg, wb_reg;
    logic [31:0] alu_data, mem_data, wb_data, busy;
    logic        issue_valid, wb_enable;

    logic [31:0] rf [32];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    regfile_wb dut (
        .clk         (clk),
        .reset       (reset),
        .alu_valid   (alu_valid),
        .alu_ready   (alu_ready),
        .alu_reg     (alu_reg),
        .alu_data    (alu_data),
        .mem_valid   (mem_valid),
        .mem_ready   (mem_ready),
        .mem_reg     (mem_reg),
        .mem_data    (mem_data),
        .issue_valid (issue_valid),
        .issue_reg   (issue_reg),
        .busy        (busy),
        .wb_enable   (wb_enable),
        .wb_reg      (wb_reg),
        .wb_data     (wb_data)
    );

    // Register file consumer model: commits whatever is enabled.
    always @(posedge clk)
        if (wb_enable) rf[wb_reg] <= wb_data;

    typedef struct {
        logic        av;
        logic [4:0]  ar;
        logic [31:0] ad;
        logic        mv;
        logic [4:0]  mr;
        logic [31:0] md;
        logic        ea;
        logic        em;
        logic        ee;
        logic [4:0]  er;
        logic [31:0] ed;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid   = 1'b0;
        mem_valid   = 1'b0;
        issue_valid = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = '0;
        reset       = 1'b0;
        alu_valid   = 1'b1;
        mem_valid   = 1'b1;
        alu_reg     = 5'd3;
        alu_data    = 32'h1;
        mem_reg     = 5'd4;
        mem_data    = 32'h2;
        issue_valid = 1'b1;
        issue_reg   = 5'd7;

        // Held in reset with both producers offering.
        tick();
        tick();
        chk("rst_alu_ready", 32'(alu_ready), 32'd0);
        chk("rst_mem_ready", 32'(mem_ready), 32'd0);
        chk("rst_wb_enable", 32'(wb_enable), 32'd0);
        chk("rst_wb_reg", 32'(wb_reg), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_busy", busy, 32'd0);
        idle();
        @(negedge clk);
        reset = 1'b1;

        vecs[0]  = '{1, 3, 32'h11, 1, 4, 32'h22, 0, 1, 1, 4, 32'h22};
        vecs[1]  = '{1, 3, 32'h11, 1, 6, 32'h33, 1, 0, 1, 3, 32'h11};
        vecs[2]  = '{1, 7, 32'h44, 1, 6, 32'h33, 0, 1, 1, 6, 32'h33};
        vecs[3]  = '{1, 7, 32'h44, 1, 8, 32'h55, 1, 0, 1, 7, 32'h44};
        vecs[4]  = '{0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 0, 7, 32'h44};
        vecs[5]  = '{1, 0, 32'hDEAD, 0, 0, 32'h0, 1, 0, 0, 0, 32'hDEAD};
        vecs[6]  = '{1, 9, 32'h66, 0, 0, 32'h0, 1, 0, 1, 9, 32'h66};
        vecs[7]  = '{0, 0, 32'h0, 1, 10, 32'h77, 0, 1, 1, 10, 32'h77};
        vecs[8]  = '{1, 11, 32'h88, 1, 12, 32'h99, 1, 0, 1, 11, 32'h88};
        vecs[9]  = '{1, 13, 32'hAA, 1, 12, 32'h99, 0, 1, 1, 12, 32'h99};
        vecs[10] = '{0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 0, 12, 32'h99};

        for (int i = 0; i < 11; i++) begin
            alu_valid = vecs[i].av;
            alu_reg   = vecs[i].ar;
            alu_data  = vecs[i].ad;
            mem_valid = vecs[i].mv;
            mem_reg   = vecs[i].mr;
            mem_data  = vecs[i].md;
            #1;
            chk($sformatf("v%0d_alu_ready", i), 32'(alu_ready), 32'(vecs[i].ea));
            chk($sformatf("v%0d_mem_ready", i), 32'(mem_ready), 32'(vecs[i].em));
            tick();
            chk($sformatf("v%0d_wb_enable", i), 32'(wb_enable), 32'(vecs[i].ee));
            chk($sformatf("v%0d_wb_reg", i), 32'(wb_reg), 32'(vecs[i].er));
            chk($sformatf("v%0d_wb_data", i), wb_data, vecs[i].ed);
            chk($sformatf("v%0d_busy", i), busy, 32'd0);
        end
        chk("r0_never_written", rf[0], 32'd0);
        chk("r7_committed", rf[7], 32'h44);

        // Scoreboard life cycle on r5.
        issue_valid = 1'b1;
        issue_reg   = 5'd5;
        tick();
        idle();
        chk("sb_set", busy, 32'(SB) << 5);
        tick();
        tick();
        chk("sb_hold", busy, 32'(SB) << 5);
        alu_valid = 1'b1;
        alu_reg   = 5'd5;
        alu_data  = 32'h5A;
        #1;
        chk("sb_alu_ready", 32'(alu_ready), 32'd1);
        tick();
        idle();
        chk("sb_wb_enable", 32'(wb_enable), 32'd1);
        chk("sb_wb_reg", 32'(wb_reg), 32'd5);
        chk("sb_busy_until_commit", busy, 32'(SB) << 5);
        tick();
        chk("sb_cleared", busy, 32'd0);
        chk("sb_rf_r5", rf[5], 32'h5A);

        // Reissue to r5 on the commit edge keeps it busy.
        issue_valid = 1'b1;
        tick();
        issue_valid = 1'b0;
        alu_valid   = 1'b1;
        alu_data    = 32'h5B;
        tick();
        alu_valid   = 1'b0;
        issue_valid = 1'b1;
        chk("sw_wb_enable", 32'(wb_enable), 32'd1);
        tick();
        idle();
        chk("set_beats_clear", busy, 32'(SB) << 5);
        tick();
        chk("set_beats_clear_hold", busy, 32'(SB) << 5);
        alu_valid = 1'b1;
        alu_data  = 32'h5C;
        tick();
        idle();
        tick();
        chk("sb_final_clear", busy, 32'd0);

        // Async reset while a write to r14 is on the output.
        issue_valid = 1'b1;
        issue_reg   = 5'd14;
        tick();
        issue_valid = 1'b0;
        mem_valid   = 1'b1;
        mem_reg     = 5'd14;
        mem_data    = 32'hBB;
        tick();
        mem_valid = 1'b0;
        chk("ar_wb_enable_pre", 32'(wb_enable), 32'd1);
        chk("ar_busy_pre", busy, 32'(SB) << 14);
        alu_valid = 1'b1;
        alu_reg   = 5'd16;
        alu_data  = 32'h10;
        mem_valid = 1'b1;
        mem_reg   = 5'd17;
        mem_data  = 32'h20;
        #2;
        reset = 1'b0;
        #1;
        chk("ar_wb_enable", 32'(wb_enable), 32'd0);
        chk("ar_wb_reg", 32'(wb_reg), 32'd0);
        chk("ar_busy", busy, 32'd0);
        chk("ar_alu_ready", 32'(alu_ready), 32'd0);
        chk("ar_mem_ready", 32'(mem_ready), 32'd0);
        tick();
        chk("ar_no_commit", rf[14], 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("post_rst_mem_ready", 32'(mem_ready), 32'd1);
        chk("post_rst_alu_ready", 32'(alu_ready), 32'd0);
        tick();
        idle();
        chk("post_rst_wb_enable", 32'(wb_enable), 32'd1);
        chk("post_rst_wb_reg", 32'(wb_reg), 32'd17);
        chk("post_rst_wb_data", wb_data, 32'h20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
